// File: rtl/reg_scan_display.sv
// reg_scan_display: read-side sequencer for the 16x4 register bank.
// Sweeps port A through the lower half of the bank and port B through the
// upper half in lock-step, captures each pair and shows the captured
// addresses/data on a 4-digit multiplexed active-low seven-segment display.
module reg_scan_display #(
  parameter int AW      = 4,
  parameter int DW      = 4,
  parameter int DWELL   = 4,
  parameter int REFRESH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] addrRa,
  output logic [AW-1:0] addrRb,
  input  logic [DW-1:0] datOutRa,
  input  logic [DW-1:0] datOutRb,
  output logic          pair_valid,
  output logic          scan_done,
  output logic [6:0]    SSeg,
  output logic [3:0]    An
);

  localparam int NP = 1 << (AW - 1);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [AW-1:0] NP_A    = AW'(NP);
  localparam logic [AW-1:0] LAST_A  = AW'(NP - 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_CAPT  = 2'd2,
    S_DWELL = 2'd3
  } state_t;

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_inc_s;
  logic [CW-1:0] dwell_cnt_r;
  logic [DW-1:0] cap_ra_r;
  logic [DW-1:0] cap_rb_r;
  logic [AW-1:0] cap_aa_r;
  logic [AW-1:0] cap_ab_r;
  logic [RW-1:0] ref_cnt_r;
  logic [1:0]    dsel_r;
  logic [3:0]    nib_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;

  // Active-low hex to seven-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next pair index; only used when idx is below the last pair, so no wrap.
  always_comb begin
    idx_inc_s = idx_r + AW'(1);
  end

  // Scan FSM: addresses are set on entry to ADDR so they are valid for the
  // whole ADDR cycle; data is latched in CAPT; pair_valid marks first DWELL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      dwell_cnt_r <= '0;
      addrRa      <= '0;
      addrRb      <= NP_A;
      cap_ra_r    <= '0;
      cap_rb_r    <= '0;
      cap_aa_r    <= '0;
      cap_ab_r    <= '0;
      pair_valid  <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      scan_done  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          idx_r  <= '0;
          addrRa <= '0;
          addrRb <= NP_A;
          if (en) begin
            state_r <= S_ADDR;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ADDR: begin
          state_r <= S_CAPT;
        end
        S_CAPT: begin
          cap_ra_r    <= datOutRa;
          cap_rb_r    <= datOutRb;
          cap_aa_r    <= addrRa;
          cap_ab_r    <= addrRb;
          dwell_cnt_r <= '0;
          pair_valid  <= 1'b1;
          scan_done   <= (idx_r == LAST_A);
          state_r     <= S_DWELL;
        end
        S_DWELL: begin
          if (dwell_cnt_r == DW_LAST) begin
            if (idx_r != LAST_A) begin
              idx_r   <= idx_inc_s;
              addrRa  <= idx_inc_s;
              addrRb  <= idx_inc_s + NP_A;
              state_r <= S_ADDR;
            end else if (en) begin
              idx_r   <= '0;
              addrRa  <= '0;
              addrRb  <= NP_A;
              state_r <= S_ADDR;
            end else begin
              idx_r   <= '0;
              addrRa  <= '0;
              addrRb  <= NP_A;
              state_r <= S_IDLE;
            end
          end else begin
            dwell_cnt_r <= dwell_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Digit source select and anode pattern for the current digit.
  always_comb begin
    case (dsel_r)
      2'd0:    nib_s = 4'(cap_rb_r);
      2'd1:    nib_s = 4'(cap_ab_r);
      2'd2:    nib_s = 4'(cap_ra_r);
      2'd3:    nib_s = 4'(cap_aa_r);
      default: nib_s = 4'(cap_rb_r);
    endcase
    an_s  = ~(4'b0001 << dsel_r);
    seg_s = hex7(nib_s);
  end

  // Free-running display refresh; anodes and segments register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_r <= '0;
      dsel_r    <= 2'd0;
      An        <= 4'b1110;
      SSeg      <= 7'b1000000;
    end else begin
      if (ref_cnt_r == RF_LAST) begin
        ref_cnt_r <= '0;
        dsel_r    <= dsel_r + 2'd1;
      end else begin
        ref_cnt_r <= ref_cnt_r + RW'(1);
      end
      An   <= an_s;
      SSeg <= seg_s;
    end
  end

endmodule

// File: tb/tb_reg_scan_display.sv
// Directed bench for reg_scan_display with a bank model where reg k holds k.
module tb_reg_scan_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] addrRa, addrRb, datOutRa, datOutRb;
  logic       pair_valid, scan_done;
  logic [6:0] SSeg;
  logic [3:0] An;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Register bank model: reg k = k, combinational read.
  assign datOutRa = addrRa;
  assign datOutRb = addrRb;

  reg_scan_display #(.AW(4), .DW(4), .DWELL(4), .REFRESH(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .addrRa(addrRa), .addrRb(addrRb),
    .datOutRa(datOutRa), .datOutRb(datOutRb),
    .pair_valid(pair_valid), .scan_done(scan_done),
    .SSeg(SSeg), .An(An)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance until pair_valid is seen; returns cycles elapsed.
  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!pair_valid && cyc < 40);
    check_eq("pulse_seen", {31'd0, pair_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    int dig;
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    // Reset
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    check_eq("rst_an",    An, 4'b1110);
    check_eq("rst_sseg",  SSeg, 7'b1000000);
    check_eq("rst_addra", addrRa, 4'd0);
    check_eq("rst_addrb", addrRb, 4'd8);
    check_eq("rst_pv",    pair_valid, 1'b0);
    check_eq("rst_sd",    scan_done, 1'b0);
    rst = 1'b0;

    // Single sweep from a one-cycle en pulse
    en = 1'b1;
    tick();
    en = 1'b0;
    check_eq("t0_addra", addrRa, 4'd0);
    check_eq("t0_addrb", addrRb, 4'd8);
    for (int i = 0; i < 8; i++) begin
      wait_pulse(cyc);
      check_eq("sweep_gap",   cyc, (i == 0) ? 2 : 6);
      check_eq("sweep_addra", addrRa, i);
      check_eq("sweep_addrb", addrRb, i + 8);
      check_eq("sweep_capra", dut.cap_ra_r, i);
      check_eq("sweep_caprb", dut.cap_rb_r, i + 8);
      check_eq("sweep_done",  scan_done, (i == 7) ? 1 : 0);
    end
    repeat (4) tick();
    check_eq("idle_addra", addrRa, 4'd0);
    check_eq("idle_addrb", addrRb, 4'd8);
    bad = 0;
    repeat (15) begin
      tick();
      if (pair_valid || addrRa != 4'd0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    // Continuous scan, then drop en during pair 3 of the second sweep
    en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      wait_pulse(cyc);
      check_eq("cont_gap",   cyc, (i == 0) ? 2 : 6);
      check_eq("cont_addra", addrRa, i % 8);
      check_eq("cont_addrb", addrRb, (i % 8) + 8);
      check_eq("cont_done",  scan_done, (i % 8 == 7) ? 1 : 0);
      if (i == 11) en = 1'b0;
    end
    repeat (4) tick();
    check_eq("stop_addra", addrRa, 4'd0);
    bad = 0;
    repeat (15) begin
      tick();
      if (pair_valid || addrRa != 4'd0) bad++;
    end
    check_eq("stop_quiet", bad, 0);

    // Display mux with pair 7 held: capRb=F, capAb=F, capRa=7, capAa=7
    prev_an = An;
    cyc = 0;
    while (!(An == 4'b1110 && prev_an == 4'b0111) && cyc < 40) begin
      prev_an = An;
      tick();
      cyc++;
    end
    check_eq("disp_sync", {31'd0, (An == 4'b1110 && prev_an == 4'b0111)}, 32'd1);
    for (int n = 0; n <= 16; n++) begin
      dig = (n / 4) % 4;
      case (dig)
        0: begin exp_an = 4'b1110; exp_seg = 7'b0001110; end
        1: begin exp_an = 4'b1101; exp_seg = 7'b0001110; end
        2: begin exp_an = 4'b1011; exp_seg = 7'b1111000; end
        default: begin exp_an = 4'b0111; exp_seg = 7'b1111000; end
      endcase
      check_eq("disp_an",   An, exp_an);
      check_eq("disp_sseg", SSeg, exp_seg);
      tick();
    end

    // Reset asserted during a CAPT cycle
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_addra", addrRa, 4'd0);
    check_eq("mrst_addrb", addrRb, 4'd8);
    check_eq("mrst_pv",    pair_valid, 1'b0);
    check_eq("mrst_capra", dut.cap_ra_r, 4'd0);
    check_eq("mrst_caprb", dut.cap_rb_r, 4'd0);
    check_eq("mrst_an",    An, 4'b1110);
    check_eq("mrst_sseg",  SSeg, 7'b1000000);
    bad = 0;
    repeat (15) begin
      tick();
      if (pair_valid || addrRa != 4'd0 || SSeg != 7'b1000000) bad++;
    end
    check_eq("mrst_quiet", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
